// File: rtl/dcache_pkg.sv
// Shared widths, FSM state encoding and address-split helpers for the
// direct-mapped write-through data cache.
package dcache_pkg;

  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_INDEX_W = 4;
  localparam int DEF_TAG_W   = DEF_ADDR_W - DEF_INDEX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic [DEF_INDEX_W-1:0] idx_of(input logic [DEF_ADDR_W-1:0] a);
    return a[DEF_INDEX_W-1:0];
  endfunction

  function automatic logic [DEF_TAG_W-1:0] tag_of(input logic [DEF_ADDR_W-1:0] a);
    return a[DEF_ADDR_W-1:DEF_INDEX_W];
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// Valid/tag/data line storage: combinational lookup, one synchronous line
// write port, valid bits cleared asynchronously by rst.
module dcache_tag_array import dcache_pkg::*; #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [INDEX_W-1:0]        rd_idx,
  input  logic [ADDR_W-INDEX_W-1:0] rd_tag,
  output logic                      hit,
  output logic [DATA_W-1:0]         rdata,
  input  logic                      wr_en,
  input  logic [INDEX_W-1:0]        wr_idx,
  input  logic [ADDR_W-INDEX_W-1:0] wr_tag,
  input  logic [DATA_W-1:0]         wr_data
);

  localparam int LINES = 2 ** INDEX_W;

  logic [LINES-1:0]          valid;
  logic [ADDR_W-INDEX_W-1:0] tag_mem  [LINES];
  logic [DATA_W-1:0]         data_mem [LINES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign hit   = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rdata = data_mem[rd_idx];

endmodule

// File: rtl/dcache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MIPS
// Memory stage. Optional hit/miss counters under DCACHE_STATS_EN.
//   state   | meaning
//   IDLE    | waiting for a strobe; lookup on the live address
//   RD_MISS | refill request outstanding to backing memory
//   WR_THRU | write-through request outstanding to backing memory
//   DONE    | request finished; wait for both strobes to go high
module dcache_dm_wt import dcache_pkg::*; #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int INDEX_W = DEF_INDEX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              r_en,
  input  logic              w_en,
  output logic [DATA_W-1:0] saida_cache,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  state_t state_q, state_d;

  logic req, is_wr, hit, line_wr;
  logic [DATA_W-1:0] line_rdata, line_wdata;
  logic [ADDR_W-1:0] line_addr;

  assign req   = !r_en || !w_en;
  assign is_wr = !w_en;

  // mem_addr doubles as the latched request address once we leave IDLE.
  assign line_addr  = (state_q == IDLE) ? address : mem_addr;
  assign line_wdata = (state_q == IDLE) ? data : mem_rdata;
  assign line_wr    = ((state_q == IDLE) && req && is_wr && hit) ||
                      ((state_q == RD_MISS) && mem_ack);

  dcache_tag_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .INDEX_W(INDEX_W)
  ) u_tags (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (idx_of(address)),
    .rd_tag (tag_of(address)),
    .hit    (hit),
    .rdata  (line_rdata),
    .wr_en  (line_wr),
    .wr_idx (idx_of(line_addr)),
    .wr_tag (tag_of(line_addr)),
    .wr_data(line_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (is_wr)    state_d = WR_THRU;
          else if (hit) state_d = DONE;
          else          state_d = RD_MISS;
        end
      end
      RD_MISS: if (mem_ack) state_d = DONE;
      WR_THRU: if (mem_ack) state_d = DONE;
      DONE:    if (r_en && w_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      saida_cache <= '0;
      stall       <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            mem_addr  <= address;
            mem_wdata <= data;
            if (is_wr) begin
              stall   <= 1'b1;
              mem_req <= 1'b1;
              mem_we  <= 1'b1;
            end else if (hit) begin
              saida_cache <= line_rdata;
            end else begin
              stall   <= 1'b1;
              mem_req <= 1'b1;
              mem_we  <= 1'b0;
            end
          end
        end
        RD_MISS: begin
          if (mem_ack) begin
            saida_cache <= mem_rdata;
            mem_req     <= 1'b0;
            stall       <= 1'b0;
          end
        end
        WR_THRU: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            stall   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if ((state_q == IDLE) && req && !is_wr) begin
      if (hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_dm_wt.sv
// Directed bench for dcache_dm_wt: bench-side memory responder, hand-computed
// expectations for miss/hit/write-through/conflict/dual-strobe/reset cases.
module tb_dcache_dm_wt;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] address;
  logic [31:0] data;
  logic        r_en, w_en;
  logic [31:0] saida_cache;
  logic        stall, mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  dcache_dm_wt dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .data       (data),
    .r_en       (r_en),
    .w_en       (w_en),
    .saida_cache(saida_cache),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          st_cnt, req_cnt;
  logic        we_seen;
  logic [11:0] addr_seen;
  logic [31:0] wdata_seen, out_first;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Hold the strobes for win cycles; answer a memory request dly cycles after it rises.
  task automatic xact(input logic [11:0] a, input logic [31:0] d, input logic rd,
                      input logic wr, input int dly, input logic [31:0] rdata, input int win);
    int   cnt;
    logic acked, prev;
    @(negedge clk);
    address = a; data = d; r_en = ~rd; w_en = ~wr;
    st_cnt = 0; req_cnt = 0; cnt = 0; acked = 1'b0; prev = 1'b0;
    we_seen = 1'bx; addr_seen = 'x; wdata_seen = 'x;
    for (int i = 0; i < win; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (i == 0) out_first = saida_cache;
      if (stall) st_cnt++;
      if (mem_req && !prev) begin
        req_cnt++;
        we_seen = mem_we; addr_seen = mem_addr; wdata_seen = mem_wdata;
      end
      prev = mem_req;
      if (mem_req && !acked) begin
        cnt++;
        if (cnt > dly) begin
          mem_ack = 1'b1; mem_rdata = rdata; acked = 1'b1;
        end
      end
    end
    mem_ack = 1'b0; r_en = 1'b1; w_en = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; address = '0; data = '0; r_en = 1'b1; w_en = 1'b1;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_saida", saida_cache, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {20'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;

    // Cold read miss, memory answers after 3 cycles.
    xact(12'h005, 32'h0, 1'b1, 1'b0, 3, 32'hDEADBEEF, 8);
    check("miss_stall_cyc", st_cnt, 4);
    check("miss_req_cnt", req_cnt, 1);
    check("miss_we", {31'd0, we_seen}, 32'd0);
    check("miss_addr", {20'd0, addr_seen}, 32'h005);
    check("miss_data", saida_cache, 32'hDEADBEEF);

    xact(12'h005, 32'h0, 1'b1, 1'b0, 0, 32'h0, 4);
    check("hit_stall_cyc", st_cnt, 0);
    check("hit_req_cnt", req_cnt, 0);
    check("hit_data_n1", out_first, 32'hDEADBEEF);

    xact(12'h005, 32'h12345678, 1'b0, 1'b1, 1, 32'h0, 6);
    check("wr_req_cnt", req_cnt, 1);
    check("wr_we", {31'd0, we_seen}, 32'd1);
    check("wr_addr", {20'd0, addr_seen}, 32'h005);
    check("wr_wdata", wdata_seen, 32'h12345678);
    check("wr_stall_cyc", st_cnt, 2);

    xact(12'h005, 32'h0, 1'b1, 1'b0, 0, 32'h0, 4);
    check("wr_hit_req_cnt", req_cnt, 0);
    check("wr_hit_data", out_first, 32'h12345678);

    // Same index, different tag: refill evicts 0x005.
    xact(12'h015, 32'h0, 1'b1, 1'b0, 0, 32'hCAFEF00D, 6);
    check("conf_req_cnt", req_cnt, 1);
    check("conf_addr", {20'd0, addr_seen}, 32'h015);
    check("conf_stall_cyc", st_cnt, 1);
    check("conf_data", saida_cache, 32'hCAFEF00D);

    xact(12'h005, 32'h0, 1'b1, 1'b0, 0, 32'hAAAA5555, 6);
    check("evict_req_cnt", req_cnt, 1);
    check("evict_data", saida_cache, 32'hAAAA5555);

    // Both strobes low and held: one write only, no allocate.
    xact(12'h003, 32'h0BADC0DE, 1'b1, 1'b1, 0, 32'h0, 13);
    check("both_req_cnt", req_cnt, 1);
    check("both_we", {31'd0, we_seen}, 32'd1);
    check("both_wdata", wdata_seen, 32'h0BADC0DE);

    xact(12'h003, 32'h0, 1'b1, 1'b0, 0, 32'h0BADC0DE, 6);
    check("noalloc_req_cnt", req_cnt, 1);
    check("noalloc_we", {31'd0, we_seen}, 32'd0);

    // Async reset in the middle of a read miss.
    @(negedge clk);
    address = 12'h015; r_en = 1'b0;
    @(negedge clk);
    check("rstmid_req_pre", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmid_req", {31'd0, mem_req}, 32'd0);
    check("rstmid_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0; r_en = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    mem_ack = 1'b0;
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    check("late_ack_stall", {31'd0, stall}, 32'd0);
    check("late_ack_saida", saida_cache, 32'd0);

    xact(12'h005, 32'h0, 1'b1, 1'b0, 1, 32'h13579BDF, 6);
    check("post_rst_req_cnt", req_cnt, 1);
    check("post_rst_data", saida_cache, 32'h13579BDF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
